// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
//
// Byte-serial multi-byte add/subtract sequencer. An operation of
// NBYTES*8 bits is broken into NBYTES byte steps (LSB first). Each step is
// evaluated by an external combinational 8-bit arithmetic ALU. The ripple
// carry (or borrow) is kept in a local register between steps.
//
// Parameters
//   NBYTES       operand width in bytes, 1..8 (default 4)
//
// Build option
//   ALU_SEQ_ZERO_FLAG_EN  when defined, adds the registered zero_o output.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous active-high reset
//   start_i      operation request, sampled only in IDLE
//   op_i         00 add, 01 add+carry-in, 10 sub, 11 sub+borrow-in
//   cin_i        carry/borrow-in, used only for op 01/11
//   a_i, b_i     operands (subtraction computes a - b)
//   busy_o       high while bytes are being processed
//   done_o       one-cycle completion pulse
//   result_o     result register
//   cout_o       final carry (add) or borrow (sub)
//   alu_rs_o     ALU operand 1 (byte of a)
//   alu_op2_o    ALU operand 2 (byte of b)
//   alu_op_o     ALU operation, always the carry/borrow-in variant
//   alu_carry_o  ALU carry/borrow-in
//   alu_res_i    ALU byte result, same cycle
//   alu_cout_i   ALU carry/borrow-out, same cycle
//   zero_o       (option) result was zero at the last completion
//
// State table
//   state   | meaning
//   IDLE    | waiting for start_i, result/cout held
//   RUN     | one byte per cycle through the external ALU
//   DONE    | done_o pulse, result and cout valid
// ----------------------------------------------------------------------------
module alu_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic                  cin_i,
    input  logic [8*NBYTES-1:0]   a_i,
    input  logic [8*NBYTES-1:0]   b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [8*NBYTES-1:0]   result_o,
    output logic                  cout_o,
    output logic [7:0]            alu_rs_o,
    output logic [7:0]            alu_op2_o,
    output logic [1:0]            alu_op_o,
    output logic                  alu_carry_o,
    input  logic [7:0]            alu_res_i,
    input  logic                  alu_cout_i
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                  zero_o
`endif
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = 3;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic [5:0]      bit_base;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic            zero_q;
`endif

    assign bit_base = {idx_q, 3'b000};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    // Evaluated on the RUN->DONE edge from the final result so the flag is
    // already valid alongside done_o; held until the next completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_q <= 1'b0;
        end else if (state_q == S_RUN && state_d == S_DONE) begin
            zero_q <= (result_d == '0);
        end
    end

    assign zero_o = zero_q;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        result_d    = result_q;
        alu_rs_o    = 8'h00;
        alu_op2_o   = 8'h00;
        alu_op_o    = 2'b00;
        alu_carry_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = op_i[1];
                    // Plain add/sub start with no carry/borrow-in.
                    carry_d = op_i[0] & cin_i;
                end
            end
            S_RUN: begin
                // Always use the carry-in ALU variant; the first byte gets
                // either cin_i or 0 through the carry register.
                alu_rs_o    = a_q[bit_base +: 8];
                alu_op2_o   = b_q[bit_base +: 8];
                alu_op_o    = {sub_q, 1'b1};
                alu_carry_o = carry_q;
                result_d[bit_base +: 8] = alu_res_i;
                carry_d     = alu_cout_i;
                idx_d       = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign cout_o   = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [1:0]    op_i;
    logic          cin_i;
    logic [W-1:0]  a_i, b_i;
    logic          busy_o, done_o, cout_o;
    logic [W-1:0]  result_o;
    logic [7:0]    alu_rs_o, alu_op2_o, alu_res_i;
    logic [1:0]    alu_op_o;
    logic          alu_carry_o, alu_cout_i;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic          zero_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    alu_seq #(.NBYTES(NB)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .cin_i       (cin_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .cout_o      (cout_o),
        .alu_rs_o    (alu_rs_o),
        .alu_op2_o   (alu_op2_o),
        .alu_op_o    (alu_op_o),
        .alu_carry_o (alu_carry_o),
        .alu_res_i   (alu_res_i),
        .alu_cout_i  (alu_cout_i)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .zero_o      (zero_o)
`endif
    );

    // 8-bit arithmetic ALU: 00 add, 01 add+carry, 10 sub, 11 sub+borrow.
    // Ninth bit of the 9-bit result is carry (add) or borrow (sub).
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'd0;
        case (alu_op_o)
            2'b00: alu_t = {1'b0, alu_rs_o} + {1'b0, alu_op2_o};
            2'b01: alu_t = {1'b0, alu_rs_o} + {1'b0, alu_op2_o} + {8'd0, alu_carry_o};
            2'b10: alu_t = {1'b0, alu_rs_o} - {1'b0, alu_op2_o};
            default: alu_t = {1'b0, alu_rs_o} - {1'b0, alu_op2_o} - {8'd0, alu_carry_o};
        endcase
    end
    assign alu_res_i  = alu_t[7:0];
    assign alu_cout_i = alu_t[8];

    // Whole-word reference: {carry/borrow, result}.
    function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op, input logic cin);
        logic ci;
        ci = op[0] ? cin : 1'b0;
        if (!op[1]) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        else        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
    endfunction

    // Drives one operation and checks the ALU-side lanes each RUN cycle.
    // lat = number of negedges after the start edge at which done_o is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input logic cin, input bit scramble,
                          output logic [W-1:0] res, output logic co, output int lat);
        logic exp_carry;
        int k;
        @(negedge clk_i);
        a_i = a; b_i = b; op_i = op; cin_i = cin; start_i = 1'b1;
        @(posedge clk_i);
        exp_carry = op[0] & cin;
        lat = 0; res = '0; co = 1'b0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk_i);
            if (done_o) begin
                lat = n; res = result_o; co = cout_o;
                n_checks++;
                if ({busy_o, alu_rs_o, alu_op2_o, alu_op_o, alu_carry_o} !== 20'd0) begin
                    n_fail++;
                    $display("FAIL done_idle_lanes: busy=%b rs=%h op2=%h op=%b c=%b, required all 0",
                             busy_o, alu_rs_o, alu_op2_o, alu_op_o, alu_carry_o);
                end
            end else if (n <= NB) begin
                k = n - 1;
                n_checks++;
                if (busy_o !== 1'b1 || alu_rs_o !== a[8*k +: 8] || alu_op2_o !== b[8*k +: 8] ||
                    alu_op_o !== {op[1], 1'b1} || alu_carry_o !== exp_carry) begin
                    n_fail++;
                    $display("FAIL run_lane k=%0d: busy=%b rs=%h op2=%h op=%b c=%b, required 1 %h %h %b %b",
                             k, busy_o, alu_rs_o, alu_op2_o, alu_op_o, alu_carry_o,
                             a[8*k +: 8], b[8*k +: 8], {op[1], 1'b1}, exp_carry);
                end
                exp_carry = alu_cout_i;
            end
            if (scramble) begin
                start_i = 1'($urandom_range(0, 1));
                a_i = $urandom; b_i = $urandom;
                op_i = 2'($urandom_range(0, 3)); cin_i = 1'($urandom_range(0, 1));
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        n_checks++;
        if (lat == 0) begin
            n_fail++;
            $display("FAIL done_timeout: no done_o within 20 cycles, required at %0d", NB + 1);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; cin_i = 1'b0; a_i = '0; b_i = '0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, result_o, cout_o, alu_rs_o, alu_op2_o, alu_op_o, alu_carry_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b res=%h cout=%b rs=%h op2=%h op=%b c=%b, required all 0",
                     busy_o, done_o, result_o, cout_o, alu_rs_o, alu_op2_o, alu_op_o, alu_carry_o);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_checks++;
        if (zero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_zero: zero_o=%b, required 0", zero_o);
        end
`endif
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [6] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000100, 32'h0, 32'h7FFFFFFF, 32'h5};
        logic [W-1:0] tb [6] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h2};
        logic [1:0]   top[6] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
        logic         tci[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] xr [6] = '{32'h00000100, 32'h0, 32'h000000FF, 32'hFFFFFFFF, 32'h80000000, 32'h2};
        logic         xc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] res;
        logic co;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], top[i], tci[i], 1'b0, res, co, lat);
            n_checks++;
            if (res !== xr[i] || co !== xc[i] || lat != NB + 1) begin
                n_fail++;
                $display("FAIL directed_%0d: res=%h cout=%b lat=%0d, required %h %b %0d",
                         i, res, co, lat, xr[i], xc[i], NB + 1);
            end
`ifdef ALU_SEQ_ZERO_FLAG_EN
            n_checks++;
            if (zero_o !== (xr[i] == '0)) begin
                n_fail++;
                $display("FAIL directed_zero_%0d: zero_o=%b, required %b", i, zero_o, xr[i] == '0);
            end
`endif
            // Values must hold in IDLE after the pulse.
            a_i = ~a_i; b_i = ~b_i;
            repeat (2) @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== xr[i] || cout_o !== xc[i]) begin
                n_fail++;
                $display("FAIL idle_hold_%0d: done=%b busy=%b res=%h cout=%b, required 0 0 %h %b",
                         i, done_o, busy_o, result_o, cout_o, xr[i], xc[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [W-1:0] res;
        logic co;
        logic [W:0] exp;
        int lat;
        exp = ref_model(32'h12345678, 32'h0F0FF0F0, 2'b10, 1'b1);
        run_op(32'h12345678, 32'h0F0FF0F0, 2'b10, 1'b1, 1'b1, res, co, lat);
        n_checks++;
        if (res !== exp[W-1:0] || co !== exp[W] || lat != NB + 1) begin
            n_fail++;
            $display("FAIL start_ignored: res=%h cout=%b lat=%0d, required %h %b %0d",
                     res, co, lat, exp[W-1:0], exp[W], NB + 1);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W-1:0] res;
        logic co;
        logic [W:0] exp;
        int lat;
        int seen;
        @(negedge clk_i);
        a_i = 32'hDEADBEEF; b_i = 32'h01020304; op_i = 2'b00; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i); start_i = 1'b0;   // byte 0
        @(negedge clk_i);                   // byte 1
        @(negedge clk_i);                   // byte 2
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, done_o, result_o, cout_o, alu_rs_o, alu_op2_o, alu_op_o, alu_carry_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_run_reset: busy=%b done=%b res=%h cout=%b rs=%h, required all 0",
                     busy_o, done_o, result_o, cout_o, alu_rs_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_run_no_done: done pulses=%0d, required 0", seen);
        end
        exp = ref_model(32'h89ABCDEF, 32'h76543210, 2'b10, 1'b0);
        run_op(32'h89ABCDEF, 32'h76543210, 2'b10, 1'b0, 1'b0, res, co, lat);
        n_checks++;
        if (res !== exp[W-1:0] || co !== exp[W]) begin
            n_fail++;
            $display("FAIL after_reset_op: res=%h cout=%b, required %h %b", res, co, exp[W-1:0], exp[W]);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, res;
        logic [1:0] op;
        logic cin, co;
        logic [W:0] exp;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom;
            if (i % 5 == 0) b = a;
            op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
            exp = ref_model(a, b, op, cin);
            run_op(a, b, op, cin, 1'($urandom_range(0, 1)), res, co, lat);
            n_checks++;
            if (res !== exp[W-1:0] || co !== exp[W] || lat != NB + 1) begin
                n_fail++;
                $display("FAIL random_%0d op=%b a=%h b=%h cin=%b: res=%h cout=%b lat=%0d, required %h %b %0d",
                         i, op, a, b, cin, res, co, lat, exp[W-1:0], exp[W], NB + 1);
            end
`ifdef ALU_SEQ_ZERO_FLAG_EN
            n_checks++;
            if (zero_o !== (exp[W-1:0] == '0)) begin
                n_fail++;
                $display("FAIL random_zero_%0d: zero_o=%b, required %b", i, zero_o, exp[W-1:0] == '0);
            end
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp;
        int last, cnt;
        exp = ref_model(32'hCAFEF00D, 32'h35011FF3, 2'b01, 1'b1);
        @(negedge clk_i);
        a_i = 32'hCAFEF00D; b_i = 32'h35011FF3; op_i = 2'b01; cin_i = 1'b1; start_i = 1'b1;
        last = -1; cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (done_o) begin
                n_checks++;
                if (result_o !== exp[W-1:0] || cout_o !== exp[W] ||
                    (last >= 0 && n - last != NB + 2)) begin
                    n_fail++;
                    $display("FAIL back_to_back: res=%h cout=%b gap=%0d, required %h %b %0d",
                             result_o, cout_o, n - last, exp[W-1:0], exp[W], NB + 2);
                end
                last = n; cnt++;
            end
        end
        start_i = 1'b0;
        n_checks++;
        if (cnt < 6) begin
            n_fail++;
            $display("FAIL back_to_back_count: %0d done pulses, required at least 6", cnt);
        end
        repeat (NB + 3) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
